// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: direction-counter encodings,
// the BTB entry layout and the 2-bit saturating counter next-state function.
package bp_pkg;

   localparam int unsigned BP_DATA_WIDTH = 32;
   localparam int unsigned BP_INDEX_BITS = 4;
   localparam int unsigned BP_TAG_BITS   = BP_DATA_WIDTH - BP_INDEX_BITS - 2;

   localparam logic [1:0] CTR_STRONG_NT = 2'b00;
   localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
   localparam logic [1:0] CTR_WEAK_T    = 2'b10;
   localparam logic [1:0] CTR_STRONG_T  = 2'b11;

   typedef struct packed {
      logic                     valid;
      logic [BP_TAG_BITS-1:0]   tag;
      logic [BP_DATA_WIDTH-1:0] target;
      logic [1:0]               ctr;
   } btb_entry_t;

   function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      if (taken) begin
         nxt = (ctr == CTR_STRONG_T) ? CTR_STRONG_T : ctr + 2'd1;
      end else begin
         nxt = (ctr == CTR_STRONG_NT) ? CTR_STRONG_NT : ctr - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating direction counter.
module sat_counter2
   import bp_pkg::*;
(
   input  logic [1:0] ctr_i,
   input  logic       taken_i,
   output logic [1:0] ctr_next_o
);

   assign ctr_next_o = sat_ctr_next(ctr_i, taken_i);

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, combinational lookup on the fetch PC,
// registered training from execute, and saturating resolve/mispredict statistics.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = BP_DATA_WIDTH,
   parameter int unsigned INDEX_BITS = BP_INDEX_BITS,
   parameter int unsigned TAG_BITS   = DATA_WIDTH - INDEX_BITS - 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] pc_in,
   output logic                  predict_valid,
   output logic                  predict_taken,
   output logic [DATA_WIDTH-1:0] predict_target,
   input  logic                  update_en,
   input  logic [DATA_WIDTH-1:0] update_pc,
   input  logic                  update_is_jump,
   input  logic                  update_taken,
   input  logic [DATA_WIDTH-1:0] update_target,
   input  logic                  update_mispredict,
   output logic [31:0]           branch_count,
   output logic [31:0]           mispredict_count
);

   localparam int unsigned ENTRIES = 1 << INDEX_BITS;

   logic [ENTRIES-1:0]    valid_q;
   logic [1:0]            ctr_q    [ENTRIES];
   logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
   logic [DATA_WIDTH-1:0] target_q [ENTRIES];

   logic [INDEX_BITS-1:0] rd_idx_s;
   logic [TAG_BITS-1:0]   rd_tag_s;
   btb_entry_t            rd_entry_s;
   logic                  rd_hit_s;

   logic [INDEX_BITS-1:0] upd_idx_s;
   logic [TAG_BITS-1:0]   upd_tag_s;
   logic                  upd_hit_s;
   logic [1:0]            upd_ctr_next_s;
   logic                  wr_en_s;
   logic                  wr_target_s;
   logic                  wr_tag_s;
   logic [1:0]            wr_ctr_s;

   logic [31:0]           branch_count_q;
   logic [31:0]           branch_count_d;
   logic [31:0]           mispredict_count_q;
   logic [31:0]           mispredict_count_d;

   logic                  unused_pc_low_s;

   assign unused_pc_low_s = ^{pc_in[1:0], update_pc[1:0]};

   assign rd_idx_s  = pc_in[INDEX_BITS+1:2];
   assign rd_tag_s  = pc_in[DATA_WIDTH-1:INDEX_BITS+2];
   assign upd_idx_s = update_pc[INDEX_BITS+1:2];
   assign upd_tag_s = update_pc[DATA_WIDTH-1:INDEX_BITS+2];

   // Lookup: reads pre-edge state only, so a same-cycle update is not bypassed.
   always_comb begin
      rd_entry_s.valid  = valid_q[rd_idx_s];
      rd_entry_s.tag    = tag_q[rd_idx_s];
      rd_entry_s.target = target_q[rd_idx_s];
      rd_entry_s.ctr    = ctr_q[rd_idx_s];
      rd_hit_s          = rd_entry_s.valid && (rd_entry_s.tag == rd_tag_s);
      predict_valid     = rd_hit_s;
      predict_taken     = rd_hit_s && rd_entry_s.ctr[1];
      if (rd_hit_s) begin
         predict_target = rd_entry_s.target;
      end else begin
         predict_target = {DATA_WIDTH{1'b0}};
      end
   end

   sat_counter2 u_sat_counter2 (
      .ctr_i      (ctr_q[upd_idx_s]),
      .taken_i    (update_taken),
      .ctr_next_o (upd_ctr_next_s)
   );

   // Training decision: hit updates the counter, a taken/jump miss allocates the slot.
   always_comb begin
      upd_hit_s   = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);
      wr_en_s     = 1'b0;
      wr_target_s = 1'b0;
      wr_tag_s    = 1'b0;
      wr_ctr_s    = ctr_q[upd_idx_s];
      if (update_en) begin
         if (upd_hit_s) begin
            wr_en_s = 1'b1;
            if (update_is_jump) begin
               wr_ctr_s    = CTR_STRONG_T;
               wr_target_s = 1'b1;
            end else begin
               wr_ctr_s    = upd_ctr_next_s;
               wr_target_s = update_taken;
            end
         end else if (update_is_jump || update_taken) begin
            wr_en_s     = 1'b1;
            wr_target_s = 1'b1;
            wr_tag_s    = 1'b1;
            wr_ctr_s    = update_is_jump ? CTR_STRONG_T : CTR_WEAK_T;
         end else begin
            wr_en_s = 1'b0;
         end
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Valid bits and direction counters, cleared by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= {ENTRIES{1'b0}};
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= CTR_STRONG_NT;
         end
      end else if (wr_en_s) begin
         valid_q[upd_idx_s] <= 1'b1;
         ctr_q[upd_idx_s]   <= wr_ctr_s;
      end
   end

   // Tag and target storage; never read unless the matching valid bit is set.
   always_ff @(posedge clk) begin
      if (rst && wr_tag_s) begin
         tag_q[upd_idx_s] <= upd_tag_s;
      end
      if (rst && wr_target_s) begin
         target_q[upd_idx_s] <= update_target;
      end
   end

   // Saturating statistics next-state.
   always_comb begin
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      if (update_en && (branch_count_q != 32'hFFFF_FFFF)) begin
         branch_count_d = branch_count_q + 32'd1;
      end else begin
         branch_count_d = branch_count_q;
      end
      if (update_en && update_mispredict && (mispredict_count_q != 32'hFFFF_FFFF)) begin
         mispredict_count_d = mispredict_count_q + 32'd1;
      end else begin
         mispredict_count_d = mispredict_count_q;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         branch_count_q     <= 32'd0;
         mispredict_count_q <= 32'd0;
      end else begin
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign branch_count     = branch_count_q;
   assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic        predict_valid;
   logic        predict_taken;
   logic [31:0] predict_target;
   logic        update_en;
   logic [31:0] update_pc;
   logic        update_is_jump;
   logic        update_taken;
   logic [31:0] update_target;
   logic        update_mispredict;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk               (clk),
      .rst               (rst),
      .pc_in             (pc_in),
      .predict_valid     (predict_valid),
      .predict_taken     (predict_taken),
      .predict_target    (predict_target),
      .update_en         (update_en),
      .update_pc         (update_pc),
      .update_is_jump    (update_is_jump),
      .update_taken      (update_taken),
      .update_target     (update_target),
      .update_mispredict (update_mispredict),
      .branch_count      (branch_count),
      .mispredict_count  (mispredict_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Lookup check packs {valid, taken, target}.
   task automatic lk(input string tag, input logic [31:0] pc, input logic v, input logic t,
                     input logic [31:0] tgt);
      pc_in = pc;
      #1;
      chk(tag, {30'd0, predict_valid, predict_taken, predict_target}, {30'd0, v, t, tgt});
   endtask

   task automatic cnt(input string tag, input logic [31:0] bc, input logic [31:0] mc);
      chk(tag, {branch_count, mispredict_count}, {bc, mc});
   endtask

   task automatic drive(input logic [31:0] pc, input logic jmp, input logic tk,
                        input logic [31:0] tgt, input logic misp);
      update_en         = 1'b1;
      update_pc         = pc;
      update_is_jump    = jmp;
      update_taken      = tk;
      update_target     = tgt;
      update_mispredict = misp;
   endtask

   task automatic tick_clear();
      @(posedge clk);
      #1;
      update_en         = 1'b0;
      update_mispredict = 1'b0;
   endtask

   task automatic upd(input logic [31:0] pc, input logic jmp, input logic tk,
                      input logic [31:0] tgt, input logic misp);
      drive(pc, jmp, tk, tgt, misp);
      tick_clear();
   endtask

   initial begin
      rst = 1'b0;
      pc_in = 32'h100;
      update_en = 1'b0; update_pc = 32'h0; update_is_jump = 1'b0;
      update_taken = 1'b0; update_target = 32'h0; update_mispredict = 1'b0;
      #12;
      lk("reset_lookup", 32'h100, 1'b0, 1'b0, 32'h0);
      cnt("reset_counts", 32'd0, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      lk("post_reset_lookup", 32'h100, 1'b0, 1'b0, 32'h0);

      upd(32'h100, 1'b0, 1'b1, 32'h200, 1'b0);                 // alloc ctr=2
      lk("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
      cnt("alloc_counts", 32'd1, 32'd0);

      upd(32'h100, 1'b0, 1'b1, 32'h200, 1'b0); lk("t1_ctr3", 32'h100, 1'b1, 1'b1, 32'h200);
      upd(32'h100, 1'b0, 1'b1, 32'h200, 1'b0); lk("t2_ctr3", 32'h100, 1'b1, 1'b1, 32'h200);
      upd(32'h100, 1'b0, 1'b1, 32'h200, 1'b0); lk("t3_ctr3", 32'h100, 1'b1, 1'b1, 32'h200);
      upd(32'h100, 1'b0, 1'b0, 32'h999, 1'b0); lk("nt1_ctr2", 32'h100, 1'b1, 1'b1, 32'h200);
      upd(32'h100, 1'b0, 1'b0, 32'h999, 1'b0); lk("nt2_ctr1", 32'h100, 1'b1, 1'b0, 32'h200);
      upd(32'h100, 1'b0, 1'b0, 32'h999, 1'b0); lk("nt3_ctr0", 32'h100, 1'b1, 1'b0, 32'h200);
      upd(32'h100, 1'b0, 1'b0, 32'h999, 1'b0); lk("nt4_ctr0", 32'h100, 1'b1, 1'b0, 32'h200);
      upd(32'h100, 1'b0, 1'b1, 32'h200, 1'b0); lk("floor_ctr1", 32'h100, 1'b1, 1'b0, 32'h200);
      upd(32'h100, 1'b0, 1'b1, 32'h220, 1'b0); lk("floor_ctr2", 32'h100, 1'b1, 1'b1, 32'h220);
      cnt("sat_counts", 32'd10, 32'd0);

      drive(32'h100, 1'b0, 1'b1, 32'h240, 1'b0);
      lk("same_cycle_old", 32'h100, 1'b1, 1'b1, 32'h220);
      tick_clear();
      lk("same_cycle_new", 32'h100, 1'b1, 1'b1, 32'h240);

      upd(32'h180, 1'b0, 1'b0, 32'h777, 1'b0);
      lk("miss_nt_noalloc", 32'h180, 1'b0, 1'b0, 32'h0);
      lk("miss_nt_keep", 32'h100, 1'b1, 1'b1, 32'h240);
      cnt("miss_nt_counts", 32'd12, 32'd0);

      upd(32'h140, 1'b0, 1'b1, 32'h300, 1'b0);
      lk("alias_old_miss", 32'h100, 1'b0, 1'b0, 32'h0);
      lk("alias_new_hit", 32'h140, 1'b1, 1'b1, 32'h300);
      lk("pc_low_ignored", 32'h143, 1'b1, 1'b1, 32'h300);

      upd(32'h40, 1'b1, 1'b1, 32'h80, 1'b1);                   // jump alloc ctr=3
      lk("jump_alloc", 32'h40, 1'b1, 1'b1, 32'h80);
      cnt("jump_counts", 32'd14, 32'd1);
      upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
      lk("jump_ctr3_to2", 32'h40, 1'b1, 1'b1, 32'h80);
      upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
      lk("jump_ctr1", 32'h40, 1'b1, 1'b0, 32'h80);
      upd(32'h40, 1'b1, 1'b0, 32'h90, 1'b1);                   // hit jump forces ctr=3
      lk("hit_jump", 32'h40, 1'b1, 1'b1, 32'h90);
      upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
      lk("hit_jump_ctr2", 32'h40, 1'b1, 1'b1, 32'h90);
      cnt("jump_hit_counts", 32'd18, 32'd2);

      update_mispredict = 1'b1;
      @(posedge clk); #1;
      update_mispredict = 1'b0;
      cnt("misp_unqualified", 32'd18, 32'd2);

      drive(32'h40, 1'b0, 1'b1, 32'h500, 1'b1);
      #1;
      rst = 1'b0;
      #1;
      cnt("async_reset_counts", 32'd0, 32'd0);
      lk("async_reset_lookup", 32'h40, 1'b0, 1'b0, 32'h0);
      tick_clear();
      #2;
      rst = 1'b1;
      #1;
      lk("reset_discard_lookup", 32'h40, 1'b0, 1'b0, 32'h0);
      cnt("reset_discard_counts", 32'd0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
